// File: rtl/vector_arith_unit_if.sv
// vector_arith_unit_if
//   Operand/result bundle between the sequencing controller (master) and
//   vector_arith_unit (slave).
//   start : launch request
//   op    : 00 add, 01 sub (A-B), 10 element-wise multiply, 11 dot product
//   len   : active element count (clamped to MAX_LEN by the unit)
//   Ain   : packed operand A, element i at [i*ELEM_W +: ELEM_W]
//   Bin   : packed operand B, same packing
//   Cout  : packed result, same packing
//   busy  : operation in progress
//   done  : one-cycle pulse when Cout is valid
//   ovf   : sticky overflow of the last completed operation
interface vector_arith_unit_if #(
   parameter int unsigned ELEM_W  = 32,
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
);
   logic                        start;
   logic [1:0]                  op;
   logic [LEN_W-1:0]            len;
   logic [MAX_LEN*ELEM_W-1:0]   Ain;
   logic [MAX_LEN*ELEM_W-1:0]   Bin;
   logic [MAX_LEN*ELEM_W-1:0]   Cout;
   logic                        busy;
   logic                        done;
   logic                        ovf;

   modport master (
      output start, op, len, Ain, Bin,
      input  Cout, busy, done, ovf
   );

   modport slave (
      input  start, op, len, Ain, Bin,
      output Cout, busy, done, ovf
   );
endinterface

// File: rtl/vector_arith_unit.sv
// vector_arith_unit
//   Element-wise signed fixed-point vector engine (add, sub, multiply, dot).
//   Operands are captured on an accepted start, processed LANES elements per
//   cycle, and the result buffer is published to Cout with a done pulse.
//
//   Ports:
//     clk   : clock, rising edge
//     rst_n : synchronous active-low reset
//     bus   : vector_arith_unit_if.slave (start/op/len/Ain/Bin in,
//             Cout/busy/done/ovf out, all outputs registered)
//
//   Build option:
//     VEC_ARITH_SAT_EN defined   -> out-of-range results saturate
//     VEC_ARITH_SAT_EN undefined -> out-of-range results wrap
//   ovf is reported identically in both builds.
module vector_arith_unit #(
   parameter int unsigned ELEM_W  = 32,
   parameter int unsigned FRAC_W  = 16,
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned LANES   = 2,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
   input logic                 clk,
   input logic                 rst_n,
   vector_arith_unit_if.slave  bus
);

   localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned PW = 2 * ELEM_W;
   // Dot accumulator: full products plus headroom for MAX_LEN terms
   localparam int unsigned AW = PW + $clog2(MAX_LEN);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   typedef logic signed [ELEM_W-1:0] elem_t;

   state_e                     state_q, state_d;
   logic [1:0]                 op_q, op_d;
   logic [LEN_W-1:0]           len_q, len_d;
   logic [LEN_W-1:0]           idx_q, idx_d;
   elem_t                      a_q [MAX_LEN];
   elem_t                      a_d [MAX_LEN];
   elem_t                      b_q [MAX_LEN];
   elem_t                      b_d [MAX_LEN];
   elem_t                      res_q [MAX_LEN];
   elem_t                      res_d [MAX_LEN];
   logic signed [AW-1:0]       acc_q, acc_d;
   logic                       ovf_acc_q, ovf_acc_d;
   logic [MAX_LEN*ELEM_W-1:0]  cout_q, cout_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic                       ovf_q, ovf_d;

   // per-lane working values
   logic [LEN_W-1:0]           lane_e;
   logic [IW-1:0]              lane_ei;
   elem_t                      lane_a, lane_b;
   logic signed [ELEM_W:0]     lane_sum;
   logic signed [PW-1:0]       lane_prod;
   logic signed [AW-1:0]       lane_wide;
   logic [ELEM_W:0]            fit_r;

   // Range-check a sign-extended value into ELEM_W; returns {ovf, value}.
   // In range iff every bit from ELEM_W-1 upward equals the sign.
   function automatic logic [ELEM_W:0] fit(input logic signed [AW-1:0] v);
      logic             o;
      logic [ELEM_W-1:0] r;
      o = ~((&v[AW-1:ELEM_W-1]) | (~|v[AW-1:ELEM_W-1]));
`ifdef VEC_ARITH_SAT_EN
      if (o)
         r = v[AW-1] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
      else
         r = v[ELEM_W-1:0];
`else
      r = v[ELEM_W-1:0];
`endif
      return {o, r};
   endfunction

   always_comb begin : next_state
      state_d   = state_q;
      op_d      = op_q;
      len_d     = len_q;
      idx_d     = idx_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      acc_d     = acc_q;
      ovf_acc_d = ovf_acc_q;
      cout_d    = cout_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ovf_d     = ovf_q;
      lane_e    = '0;
      lane_ei   = '0;
      lane_a    = '0;
      lane_b    = '0;
      lane_sum  = '0;
      lane_prod = '0;
      lane_wide = '0;
      fit_r     = '0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               op_d  = bus.op;
               len_d = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;
               for (int unsigned i = 0; i < MAX_LEN; i++) begin
                  a_d[i]   = bus.Ain[i*ELEM_W +: ELEM_W];
                  b_d[i]   = bus.Bin[i*ELEM_W +: ELEM_W];
                  res_d[i] = '0;
               end
               acc_d     = '0;
               ovf_acc_d = 1'b0;
               idx_d     = '0;
               busy_d    = 1'b1;
               state_d   = (len_d == '0) ? DONE : RUN;
            end
         end

         RUN: begin
            for (int unsigned l = 0; l < LANES; l++) begin
               lane_e    = idx_q + LEN_W'(l);
               lane_ei   = IW'(lane_e);
               lane_a    = a_q[lane_ei];
               lane_b    = b_q[lane_ei];
               lane_sum  = (op_q == 2'b01) ?
                           ((ELEM_W+1)'(lane_a) - (ELEM_W+1)'(lane_b)) :
                           ((ELEM_W+1)'(lane_a) + (ELEM_W+1)'(lane_b));
               lane_prod = PW'(lane_a) * PW'(lane_b);
               lane_wide = op_q[1] ? AW'(lane_prod >>> FRAC_W) : AW'(lane_sum);
               fit_r     = fit(lane_wide);
               // Inactive lanes leave the buffer at its cleared value of 0
               if (lane_e < len_q) begin
                  if (op_q == 2'b11) begin
                     acc_d = acc_d + AW'(lane_prod);
                  end else begin
                     res_d[lane_ei] = fit_r[ELEM_W-1:0];
                     ovf_acc_d      = ovf_acc_d | fit_r[ELEM_W];
                  end
               end
            end
            idx_d = idx_q + LEN_W'(LANES);
            if (idx_d >= len_q)
               state_d = DONE;
         end

         DONE: begin
            for (int unsigned i = 0; i < MAX_LEN; i++)
               cout_d[i*ELEM_W +: ELEM_W] = res_q[i];
            ovf_d = ovf_acc_q;
            // Dot result is scaled once at the end, keeping full precision in the sum
            if (op_q == 2'b11) begin
               fit_r                 = fit(acc_q >>> FRAC_W);
               cout_d[ELEM_W-1:0]    = fit_r[ELEM_W-1:0];
               ovf_d                 = ovf_acc_q | fit_r[ELEM_W];
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin : regs
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         a_q       <= '{default: '0};
         b_q       <= '{default: '0};
         res_q     <= '{default: '0};
         acc_q     <= '0;
         ovf_acc_q <= 1'b0;
         cout_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         a_q       <= a_d;
         b_q       <= b_d;
         res_q     <= res_d;
         acc_q     <= acc_d;
         ovf_acc_q <= ovf_acc_d;
         cout_q    <= cout_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.Cout = cout_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_vector_arith_unit.sv
// tb_vector_arith_unit
//   Self-checking bench for vector_arith_unit (ELEM_W=32, FRAC_W=16,
//   MAX_LEN=8, LANES=2). Results are predicted with wide signed arithmetic.
module tb_vector_arith_unit;

   localparam int unsigned W  = 32;
   localparam int unsigned FW = 16;
   localparam int unsigned ML = 8;
   localparam int unsigned LN = 2;
   localparam logic signed [95:0] MAXV = 96'sd2147483647;
   localparam logic signed [95:0] MINV = -96'sd2147483648;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   vector_arith_unit_if #(.ELEM_W(W), .MAX_LEN(ML)) vif ();

   vector_arith_unit #(
      .ELEM_W (W),
      .FRAC_W (FW),
      .MAX_LEN(ML),
      .LANES  (LN)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (vif.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] va [8];
   logic [31:0] vb [8];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] fit_ref(input logic signed [95:0] v, inout bit o);
      if (v > MAXV || v < MINV) begin
         o = 1'b1;
`ifdef VEC_ARITH_SAT_EN
         return (v > MAXV) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
         return v[31:0];
`endif
      end
      return v[31:0];
   endfunction

   // Mathematical result of the operation on the first lc elements
   function automatic void model(input logic [1:0] op, input int lc,
                                 output logic [31:0] e [8], output bit o);
      logic signed [95:0] x, y, acc;
      o   = 1'b0;
      acc = '0;
      for (int i = 0; i < 8; i++) begin
         e[i] = '0;
         if (i < lc) begin
            x = 96'($signed(va[i]));
            y = 96'($signed(vb[i]));
            case (op)
               2'b00: e[i] = fit_ref(x + y, o);
               2'b01: e[i] = fit_ref(x - y, o);
               2'b10: e[i] = fit_ref((x * y) >>> FW, o);
               default: acc = acc + x * y;
            endcase
         end
      end
      if (op == 2'b11) e[0] = fit_ref(acc >>> FW, o);
   endfunction

   function automatic logic [255:0] pack(input logic [31:0] v [8]);
      logic [255:0] p;
      for (int i = 0; i < 8; i++) p[i*32 +: 32] = v[i];
      return p;
   endfunction

   function automatic logic [31:0] rand_elem();
      case ($urandom_range(0, 3))
         0: return $urandom();
         1: return 32'($urandom_range(0, 32'h7FFFF)) - 32'h40000;
         2: return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
         default: return 32'($urandom_range(0, 100));
      endcase
   endfunction

   task automatic scramble();
      for (int i = 0; i < 8; i++) begin
         vif.Ain[i*32 +: 32] = $urandom();
         vif.Bin[i*32 +: 32] = $urandom();
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [3:0] len,
                         input string tag, input bit poke);
      int lc, exp_lat, lat;
      logic [31:0] e [8];
      bit eo, busy_ok, dup;
      lc = (len > 8) ? 8 : int'(len);
      model(op, lc, e, eo);
      @(negedge clk);
      vif.op    = op;
      vif.len   = len;
      vif.Ain   = pack(va);
      vif.Bin   = pack(vb);
      vif.start = 1'b1;
      @(posedge clk); #1;
      vif.start = 1'b0;
      scramble();
      check_eq({tag, "_busy"}, 64'(vif.busy), 64'd1);
      exp_lat = (lc + 1) / 2 + 1;
      lat     = 0;
      busy_ok = 1'b1;
      while (!vif.done && lat < 20) begin
         vif.start = (poke && lat == 1);
         @(posedge clk); #1;
         lat++;
         if (!vif.done && !vif.busy) busy_ok = 1'b0;
      end
      vif.start = 1'b0;
      check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, "_busyrun"}, 64'(busy_ok), 64'd1);
      check_eq({tag, "_busydone"}, 64'(vif.busy), 64'd0);
      for (int i = 0; i < 8; i++)
         check_eq($sformatf("%s_c%0d", tag, i), 64'(vif.Cout[i*32 +: 32]), 64'(e[i]));
      check_eq({tag, "_ovf"}, 64'(vif.ovf), 64'(eo));
      dup = 1'b0;
      repeat (poke ? 6 : 1) begin
         @(posedge clk); #1;
         if (vif.done) dup = 1'b1;
      end
      check_eq({tag, "_single"}, 64'(dup), 64'd0);
   endtask

   initial begin : stim
      int lat;
      bit eo, saw;
      logic [31:0] e [8];

      rst_n     = 1'b0;
      vif.start = 1'b0;
      vif.op    = '0;
      vif.len   = '0;
      vif.Ain   = '0;
      vif.Bin   = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_cout", 64'(|vif.Cout), 64'd0);
      check_eq("rst_busy", 64'(vif.busy), 64'd0);
      check_eq("rst_done", 64'(vif.done), 64'd0);
      check_eq("rst_ovf",  64'(vif.ovf),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // add, len=4
      for (int i = 0; i < 8; i++) begin va[i] = $urandom(); vb[i] = $urandom(); end
      for (int i = 0; i < 4; i++) begin va[i] = 32'(i + 1); vb[i] = 32'(10 * (i + 1)); end
      run_op(2'b00, 4'd4, "add4", 1'b0);

      // sub overflow, len=1
      va[0] = 32'h8000_0000; vb[0] = 32'd1;
      run_op(2'b01, 4'd1, "subovf", 1'b0);

      // reset in the middle of RUN discards the operation
      for (int i = 0; i < 8; i++) begin va[i] = 32'd5; vb[i] = 32'd6; end
      @(negedge clk);
      vif.op = 2'b00; vif.len = 4'd8; vif.Ain = pack(va); vif.Bin = pack(vb);
      vif.start = 1'b1;
      @(posedge clk); #1;
      vif.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_eq("midrst_busy", 64'(vif.busy), 64'd0);
      check_eq("midrst_done", 64'(vif.done), 64'd0);
      check_eq("midrst_cout", 64'(|vif.Cout), 64'd0);
      check_eq("midrst_ovf",  64'(vif.ovf),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (vif.done || vif.busy) saw = 1'b1;
      end
      check_eq("midrst_quiet", 64'(saw), 64'd0);

      // multiply, len=2
      va[0] = 32'h0001_8000; vb[0] = 32'hFFFE_0000;
      va[1] = 32'h0002_0000; vb[1] = 32'h0000_8000;
      run_op(2'b10, 4'd2, "mul2", 1'b0);

      // dot, len=3
      for (int i = 0; i < 3; i++) begin
         va[i] = 32'((i + 1) << 16);
         vb[i] = 32'((i + 4) << 16);
      end
      run_op(2'b11, 4'd3, "dot3", 1'b0);

      // length edges
      run_op(2'b00, 4'd0, "len0", 1'b0);
      for (int i = 0; i < 8; i++) begin va[i] = 32'd1; vb[i] = 32'd1; end
      run_op(2'b00, 4'd9, "len9", 1'b0);

      // start pulsed during RUN is ignored
      for (int i = 0; i < 8; i++) begin va[i] = 32'(i * 3); vb[i] = 32'(i); end
      run_op(2'b01, 4'd8, "poke", 1'b1);

      // back-to-back relaunch with start held high
      for (int i = 0; i < 8; i++) begin va[i] = 32'(i + 1); vb[i] = 32'd100; end
      @(negedge clk);
      vif.op = 2'b00; vif.len = 4'd2; vif.Ain = pack(va); vif.Bin = pack(vb);
      vif.start = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (!vif.done && lat < 20) begin @(posedge clk); #1; lat++; end
      check_eq("b2b_lat1", 64'(lat), 64'd2);
      for (int i = 0; i < 8; i++) begin va[i] = 32'(i * 7 + 3); vb[i] = 32'd5; end
      vif.Ain = pack(va);
      vif.Bin = pack(vb);
      model(2'b00, 2, e, eo);
      @(posedge clk); #1;
      vif.start = 1'b0;
      check_eq("b2b_relaunch", 64'(vif.busy), 64'd1);
      lat = 0;
      while (!vif.done && lat < 20) begin @(posedge clk); #1; lat++; end
      check_eq("b2b_lat2", 64'(lat), 64'd2);
      for (int i = 0; i < 3; i++)
         check_eq($sformatf("b2b_c%0d", i), 64'(vif.Cout[i*32 +: 32]), 64'(e[i]));
      @(posedge clk); #1;

      // randomized operations
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 8; i++) begin va[i] = rand_elem(); vb[i] = rand_elem(); end
         run_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 10)),
                $sformatf("rnd%0d", n), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vector_arith_unit.md
# vector_arith_unit

Parametrised element-wise vector arithmetic engine for signed fixed-point vectors packed into flat buses. It supersedes the fixed 6-element add/sub unit. It adds configurable element width, maximum length and lane count, plus fixed-point multiply and dot-product modes, and reports overflow. It sits beside the matrix/kinematics datapath and is driven by a start/done handshake from the sequencing controller.

## Interface
- `ELEM_W`, 32: element width in bits, signed.
- `FRAC_W`, 16: fractional bits (Q(ELEM_W-FRAC_W).FRAC_W).
- `MAX_LEN`, 8: maximum elements per vector.
- `LANES`, 2: elements processed per RUN cycle; must divide MAX_LEN.
- `LEN_W`, $clog2(MAX_LEN+1): width of `len`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  launch request, sampled only in IDLE.
- `op`  in  2  00 add, 01 sub (A-B), 10 element-wise multiply, 11 dot product.
- `len`  in  LEN_W  active element count; values > MAX_LEN are clamped to MAX_LEN.
- `Ain`  in  MAX_LEN*ELEM_W  packed A; element i at [i*ELEM_W +: ELEM_W].
- `Bin`  in  MAX_LEN*ELEM_W  packed B; same packing as Ain.
- `Cout`  out  MAX_LEN*ELEM_W  packed result; same packing.
- `busy`  out  1  high from the cycle after start is accepted until done.
- `done`  out  1  one-cycle pulse when Cout is valid.
- `ovf`  out  1  sticky per operation; high if any result exceeded the ELEM_W range.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**: `start`=1 captures Ain, Bin, op and clamped len into internal registers. It clears the result buffer, the accumulator, the overflow flag and idx. Next state is RUN, or DONE if len=0. Operands may change freely after capture.
- **RUN**: each cycle processes elements idx..idx+LANES-1. Elements with index ≥ len produce 0. idx advances by LANES. When idx+LANES ≥ len, next state is DONE.
- **DONE**: Cout is loaded from the result buffer, `done`=1, `ovf` is updated, `busy`=0. Next state is IDLE.
- Add and sub: full ELEM_W+1 result, then range-checked into ELEM_W.
- Multiply: 2*ELEM_W product, arithmetic right shift by FRAC_W (rounds toward −inf), then range-checked.
- Dot: products are summed unshifted into an accumulator of 2*ELEM_W+$clog2(MAX_LEN) bits. At DONE the sum is shifted right by FRAC_W, range-checked and written to element 0. All other elements are 0.
- Range-check failure sets `ovf`. The stored value depends on the Configuration macro.
- Cout and ovf hold their values until the next DONE or reset.

## Timing
- Reset (`rst_n`=0 at an edge) forces IDLE and sets Cout=0, done=0, busy=0, ovf=0. This applies in any state, including mid-RUN; the operation in progress is discarded with no done pulse.
- `start` is accepted at edge E (state IDLE). `busy` is 1 from E. `done` is high for exactly one cycle after edge E+ceil(len/LANES)+1.
  - With len=0, `done` follows edge E+1.
- `start` during RUN or DONE is ignored.
- If `start` is still high when IDLE is re-entered, it relaunches with the current Ain/Bin. This gives back-to-back throughput of one operation per ceil(len/LANES)+2 cycles.
- No combinational path from inputs to outputs.

## Configuration
- `VEC_ARITH_SAT_EN` defined: out-of-range results clamp to the most positive or most negative ELEM_W value.
- `VEC_ARITH_SAT_EN` undefined: out-of-range results wrap (low ELEM_W bits kept).
- `ovf` is reported identically in both builds.

## Test plan
Defaults: ELEM_W=32, FRAC_W=16, MAX_LEN=8, LANES=2.
- **Add, len=4**: A={1,2,3,4}, B={10,20,30,40} (raw) -> Cout={11,22,33,44,0,0,0,0}, ovf=0, done 3 cycles after the start edge, busy high throughout.
- **Sub overflow, len=1**: A0=0x80000000, B0=1 -> ovf=1; Cout[0]=0x80000000 with SAT_EN, 0x7FFFFFFF without.
- **Multiply, len=2**: A={0x00018000, 0x00020000}, B={0xFFFE0000, 0x00008000} (1.5×−2.0, 2.0×0.5) -> Cout[0]=0xFFFD0000, Cout[1]=0x00010000.
- **Dot, len=3**: A={1.0,2.0,3.0}, B={4.0,5.0,6.0} -> Cout[0]=0x00200000 (32.0), elements 1-7 =0, done 3 cycles after start.
- **Length edges**: len=0 -> done 1 cycle after start, Cout all 0. len=9 with all elements 1+1 -> treated as 8, all eight results =2, done 5 cycles after start.
- **Control**: pulse start again during RUN -> ignored, single done. Assert rst_n=0 mid-RUN -> next cycle busy=0, done=0, Cout=0, ovf=0, and no done pulse follows.
